// File: rtl/decode_sequencer.sv
// -----------------------------------------------------------------------------
// decode_sequencer
// Top-level scheduler for the image decoder. Runs the phases in a fixed order:
// UART load, then M2 (IDCT), then M1 (upsample + CSC). It owns the single
// external SRAM port through one registered owner select that drives a
// combinational address/data/we_n mux. It issues one-cycle start pulses to
// the milestone blocks, watches their Stop levels and reports done, timeout
// and per-phase RUN-cycle counts.
//
// Ports
//   Clock, Resetn               clock (rising edge), async active-low reset
//   Go                          start a decode run (only honoured in IDLE)
//   uart_done                   UART loader finished filling SRAM (level)
//   uart_SRAM_*                 UART requester address / write data / we_n
//   M2_start / M2_stop          start pulse to M2 / M2 finished level
//   M2_SRAM_*                   M2 requester address / write data / we_n
//   M1_start / M1_stop          start pulse to M1 / M1 finished level
//   M1_SRAM_*                   M1 requester address / write data / we_n
//   SRAM_address/write_data/we_n  muxed port to the SRAM controller
//   owner                       0 = UART, 1 = M2, 2 = M1, 3 = none
//   busy, done, timeout_error   status levels
//   phase_cycles                RUN-cycle count of last completed phase
// -----------------------------------------------------------------------------
module decode_sequencer #(
    parameter bit          SKIP_M2        = 1'b0,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd4000000
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Go,
    input  logic        uart_done,
    input  logic [17:0] uart_SRAM_address,
    input  logic [15:0] uart_SRAM_write_data,
    input  logic        uart_SRAM_we_n,
    output logic        M2_start,
    input  logic        M2_stop,
    input  logic [17:0] M2_SRAM_address,
    input  logic [15:0] M2_SRAM_write_data,
    input  logic        M2_SRAM_we_n,
    output logic        M1_start,
    input  logic        M1_stop,
    input  logic [17:0] M1_SRAM_address,
    input  logic [15:0] M1_SRAM_write_data,
    input  logic        M1_SRAM_we_n,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic [1:0]  owner,
    output logic        busy,
    output logic        done,
    output logic        timeout_error,
    output logic [31:0] phase_cycles
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_M2_KICK = 4'd2,
        S_M2_RUN  = 4'd3,
        S_GAP     = 4'd4,
        S_M1_KICK = 4'd5,
        S_M1_RUN  = 4'd6,
        S_DONE    = 4'd7,
        S_ERROR   = 4'd8
    } state_t;

    localparam logic [1:0] OWN_UART = 2'd0;
    localparam logic [1:0] OWN_M2   = 2'd1;
    localparam logic [1:0] OWN_M1   = 2'd2;
    localparam logic [1:0] OWN_NONE = 2'd3;

    state_t      r_state;
    logic [1:0]  r_owner;
    logic [31:0] r_counter;
    logic [31:0] r_phase_cycles;
    logic        r_m2_start;
    logic        r_m1_start;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout_error;

    state_t      w_next_state;
    logic [1:0]  w_next_owner;
    logic [31:0] w_next_counter;
    logic [31:0] w_next_phase;
    logic [31:0] w_count_inc;
    logic        w_timeout_hit;
    logic        w_next_busy;
    logic        w_stop_gate;

    // Next-state, owner, counter and phase-count computation.
    always_comb begin
        w_next_state   = r_state;
        w_next_owner   = r_owner;
        w_next_counter = r_counter;
        w_next_phase   = r_phase_cycles;
        w_count_inc    = r_counter + 32'd1;
        // counter holds the RUN cycles already completed, so on the last
        // allowed RUN cycle it reads TIMEOUT_CYCLES-1.
        w_timeout_hit  = (r_counter == (TIMEOUT_CYCLES - 32'd1));

        case (r_state)
            S_IDLE: begin
                w_next_owner = OWN_UART;
                if (Go) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD: begin
                if (uart_done) begin
                    if (SKIP_M2) begin
                        w_next_state = S_M1_KICK;
                    end else begin
                        w_next_state = S_M2_KICK;
                    end
                end else begin
                    w_next_state = S_LOAD;
                end
            end
            S_M2_KICK: begin
                // A stop seen here is deliberately ignored; it is taken on
                // the first RUN cycle because the level is sticky.
                w_next_owner   = OWN_M2;
                w_next_counter = 32'd0;
                w_next_state   = S_M2_RUN;
            end
            S_M2_RUN: begin
                w_next_counter = w_count_inc;
                // Stop is tested first so it wins over a coincident timeout.
                // The reported count includes the stop cycle itself.
                if (M2_stop) begin
                    w_next_phase = w_count_inc;
                    w_next_owner = OWN_NONE;
                    w_next_state = S_GAP;
                end else if (w_timeout_hit) begin
                    w_next_owner = OWN_NONE;
                    w_next_state = S_ERROR;
                end else begin
                    w_next_state = S_M2_RUN;
                end
            end
            S_GAP: begin
                // One dead cycle with no owner so M2 and M1 never overlap.
                w_next_owner = OWN_NONE;
                w_next_state = S_M1_KICK;
            end
            S_M1_KICK: begin
                w_next_owner   = OWN_M1;
                w_next_counter = 32'd0;
                w_next_state   = S_M1_RUN;
            end
            S_M1_RUN: begin
                w_next_counter = w_count_inc;
                if (M1_stop) begin
                    w_next_phase = w_count_inc;
                    w_next_owner = OWN_NONE;
                    w_next_state = S_DONE;
                end else if (w_timeout_hit) begin
                    w_next_owner = OWN_NONE;
                    w_next_state = S_ERROR;
                end else begin
                    w_next_state = S_M1_RUN;
                end
            end
            S_DONE: begin
                // Terminal: milestone Stop flags only clear on reset.
                w_next_owner = OWN_NONE;
                w_next_state = S_DONE;
            end
            S_ERROR: begin
                w_next_owner = OWN_NONE;
                w_next_state = S_ERROR;
            end
            default: begin
                w_next_owner   = OWN_UART;
                w_next_counter = 32'd0;
                w_next_state   = S_IDLE;
            end
        endcase
    end

    // Busy covers every state from LOAD through M1_RUN, GAP included.
    always_comb begin
        case (w_next_state)
            S_LOAD, S_M2_KICK, S_M2_RUN, S_GAP, S_M1_KICK, S_M1_RUN: begin
                w_next_busy = 1'b1;
            end
            default: begin
                w_next_busy = 1'b0;
            end
        endcase
    end

    // State, counters and status outputs; flags are decoded from the next
    // state so they line up with the state register cycle for cycle.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state         <= S_IDLE;
            r_owner         <= OWN_UART;
            r_counter       <= 32'd0;
            r_phase_cycles  <= 32'd0;
            r_m2_start      <= 1'b0;
            r_m1_start      <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_timeout_error <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_owner         <= w_next_owner;
            r_counter       <= w_next_counter;
            r_phase_cycles  <= w_next_phase;
            r_m2_start      <= (w_next_state == S_M2_KICK);
            r_m1_start      <= (w_next_state == S_M1_KICK);
            r_busy          <= w_next_busy;
            r_done          <= (w_next_state == S_DONE);
            r_timeout_error <= (w_next_state == S_ERROR);
        end
    end

    // M1 keeps writing after raising Stop, so a requester's writes are
    // blocked in the very cycle its Stop is seen during RUN.
    assign w_stop_gate = ((r_state == S_M2_RUN) && M2_stop) ||
                         ((r_state == S_M1_RUN) && M1_stop);

    // SRAM port mux selected by the registered owner.
    always_comb begin
        case (r_owner)
            OWN_UART: begin
                SRAM_address    = uart_SRAM_address;
                SRAM_write_data = uart_SRAM_write_data;
                SRAM_we_n       = uart_SRAM_we_n;
            end
            OWN_M2: begin
                SRAM_address    = M2_SRAM_address;
                SRAM_write_data = M2_SRAM_write_data;
                SRAM_we_n       = M2_SRAM_we_n;
            end
            OWN_M1: begin
                SRAM_address    = M1_SRAM_address;
                SRAM_write_data = M1_SRAM_write_data;
                SRAM_we_n       = M1_SRAM_we_n;
            end
            default: begin
                SRAM_address    = 18'd0;
                SRAM_write_data = 16'd0;
                SRAM_we_n       = 1'b1;
            end
        endcase
        if (w_stop_gate) begin
            SRAM_we_n = 1'b1;
        end else begin
            SRAM_we_n = SRAM_we_n;
        end
    end

    assign M2_start      = r_m2_start;
    assign M1_start      = r_m1_start;
    assign owner         = r_owner;
    assign busy          = r_busy;
    assign done          = r_done;
    assign timeout_error = r_timeout_error;
    assign phase_cycles  = r_phase_cycles;

endmodule

// File: tb/tb_decode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_decode_sequencer
// Bench for decode_sequencer. Two instances: u_dut (SKIP_M2=0, timeout 150)
// and u_skip (SKIP_M2=1, timeout 50); the idle one is held in reset. Each
// scenario is described by a timeline (Go cycle, uart_done cycle, Stop
// cycles); the reference model turns that timeline into the expected outputs
// for every cycle with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_decode_sequencer;

    localparam int BIG = 100000000;

    logic        Clock = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic        Go, uart_done, M2_stop, M1_stop;
    logic [17:0] u_addr, m2_addr, m1_addr;
    logic [15:0] u_data, m2_data, m1_data;
    logic        u_we, m2_we, m1_we;

    logic        a_m2s, a_m1s, a_we, a_busy, a_done, a_err;
    logic [17:0] a_addr;
    logic [15:0] a_data;
    logic [1:0]  a_owner;
    logic [31:0] a_phase;
    logic        b_m2s, b_m1s, b_we, b_busy, b_done, b_err;
    logic [17:0] b_addr;
    logic [15:0] b_data;
    logic [1:0]  b_owner;
    logic [31:0] b_phase;

    logic [73:0] obs_a, obs_b, obs, e_vec;

    bit sc_skip, we_zero;
    int sc_T, go_t, ud_t, s2_t, s1_t;
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 Clock = ~Clock;

    decode_sequencer #(.SKIP_M2(1'b0), .TIMEOUT_CYCLES(32'd150)) u_dut (
        .Clock(Clock), .Resetn(rst_a_n), .Go(Go), .uart_done(uart_done),
        .uart_SRAM_address(u_addr), .uart_SRAM_write_data(u_data), .uart_SRAM_we_n(u_we),
        .M2_start(a_m2s), .M2_stop(M2_stop),
        .M2_SRAM_address(m2_addr), .M2_SRAM_write_data(m2_data), .M2_SRAM_we_n(m2_we),
        .M1_start(a_m1s), .M1_stop(M1_stop),
        .M1_SRAM_address(m1_addr), .M1_SRAM_write_data(m1_data), .M1_SRAM_we_n(m1_we),
        .SRAM_address(a_addr), .SRAM_write_data(a_data), .SRAM_we_n(a_we),
        .owner(a_owner), .busy(a_busy), .done(a_done), .timeout_error(a_err),
        .phase_cycles(a_phase)
    );

    decode_sequencer #(.SKIP_M2(1'b1), .TIMEOUT_CYCLES(32'd50)) u_skip (
        .Clock(Clock), .Resetn(rst_b_n), .Go(Go), .uart_done(uart_done),
        .uart_SRAM_address(u_addr), .uart_SRAM_write_data(u_data), .uart_SRAM_we_n(u_we),
        .M2_start(b_m2s), .M2_stop(M2_stop),
        .M2_SRAM_address(m2_addr), .M2_SRAM_write_data(m2_data), .M2_SRAM_we_n(m2_we),
        .M1_start(b_m1s), .M1_stop(M1_stop),
        .M1_SRAM_address(m1_addr), .M1_SRAM_write_data(m1_data), .M1_SRAM_we_n(m1_we),
        .SRAM_address(b_addr), .SRAM_write_data(b_data), .SRAM_we_n(b_we),
        .owner(b_owner), .busy(b_busy), .done(b_done), .timeout_error(b_err),
        .phase_cycles(b_phase)
    );

    assign obs_a = {a_owner, a_m2s, a_m1s, a_busy, a_done, a_err, a_we, a_addr, a_data, a_phase};
    assign obs_b = {b_owner, b_m2s, b_m1s, b_busy, b_done, b_err, b_we, b_addr, b_data, b_phase};
    assign obs   = sc_skip ? obs_b : obs_a;

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Reference model: expected outputs during cycle t of the current timeline.
    // Phase codes: 0 idle, 1 load, 2 M2 kick, 3 M2 run, 4 gap, 5 M1 kick,
    // 6 M1 run, 7 done, 8 error.
    task automatic model_at(input int t, output logic [73:0] e);
        int kick2, kick1, r2, r1, err_t, done_t, ph;
        logic [1:0]  own;
        logic        we;
        logic [17:0] ad;
        logic [15:0] da;
        logic [31:0] pc;
        kick2 = BIG; kick1 = BIG; r2 = BIG; r1 = BIG; err_t = BIG; done_t = BIG;
        if (!sc_skip) begin
            kick2 = ud_t + 1;
            r2 = imax(s2_t, kick2 + 1);
            if (r2 - kick2 > sc_T) err_t = kick2 + sc_T + 1;
            else kick1 = r2 + 2;
        end else begin
            kick1 = ud_t + 1;
        end
        if (kick1 != BIG) begin
            r1 = imax(s1_t, kick1 + 1);
            if (r1 - kick1 > sc_T) err_t = kick1 + sc_T + 1;
            else done_t = r1 + 1;
        end
        if (t <= go_t)                       ph = 0;
        else if (t >= err_t)                 ph = 8;
        else if (t >= done_t)                ph = 7;
        else if (t > kick1)                  ph = 6;
        else if (t == kick1)                 ph = 5;
        else if (!sc_skip && t == r2 + 1)    ph = 4;
        else if (t > kick2)                  ph = 3;
        else if (t == kick2)                 ph = 2;
        else                                 ph = 1;
        case (ph)
            0, 1, 2: own = 2'd0;
            3:       own = 2'd1;
            5:       own = sc_skip ? 2'd0 : 2'd3;
            6:       own = 2'd2;
            default: own = 2'd3;
        endcase
        pc = 32'd0;
        if (!sc_skip && (r2 - kick2) <= sc_T && t >= r2 + 1) pc = 32'(r2 - kick2);
        if (done_t != BIG && t >= done_t) pc = 32'(r1 - kick1);
        case (own)
            2'd0: begin ad = u_addr;  da = u_data;  we = u_we; end
            2'd1: begin ad = m2_addr; da = m2_data; we = M2_stop ? 1'b1 : m2_we; end
            2'd2: begin ad = m1_addr; da = m1_data; we = M1_stop ? 1'b1 : m1_we; end
            default: begin ad = 18'd0; da = 16'd0; we = 1'b1; end
        endcase
        e = {own, (ph == 2), (ph == 5), (ph >= 1 && ph <= 6), (ph == 7), (ph == 8),
             we, ad, da, pc};
    endtask

    // Stimulus for cycle t: Go pulse plus random extra Go pulses that must be ignored.
    task automatic drive_at(input int t);
        Go        = (t == go_t) || (t > go_t && $urandom_range(0, 3) == 0);
        uart_done = (t >= ud_t);
        M2_stop   = (t >= s2_t);
        M1_stop   = (t >= s1_t);
        u_addr  = 18'($urandom());  u_data  = 16'($urandom());
        m2_addr = 18'($urandom());  m2_data = 16'($urandom());
        m1_addr = 18'($urandom());  m1_data = 16'($urandom());
        u_we  = we_zero ? 1'b0 : 1'($urandom_range(0, 1));
        m2_we = we_zero ? 1'b0 : 1'($urandom_range(0, 1));
        m1_we = we_zero ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic clear_inputs();
        Go = 1'b0; uart_done = 1'b0; M2_stop = 1'b0; M1_stop = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        if (sc_skip) rst_b_n = 1'b1; else rst_a_n = 1'b1;
    endtask

    task automatic test_reset();
        sc_skip = 1'b0;
        clear_inputs();
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        u_addr = 18'h2A5A5; u_data = 16'hC3E1; u_we = 1'b0;
        m2_addr = 18'h1; m2_data = 16'h2; m2_we = 1'b0;
        m1_addr = 18'h3; m1_data = 16'h4; m1_we = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        e_vec = {2'd0, 5'b00000, 1'b0, 18'h2A5A5, 16'hC3E1, 32'd0};
        total_cnt++;
        if (obs_a !== e_vec) $display("FAIL reset_a got=%h want=%h", obs_a, e_vec);
        else pass_cnt++;
        total_cnt++;
        if (obs_b !== e_vec) $display("FAIL reset_b got=%h want=%h", obs_b, e_vec);
        else pass_cnt++;
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(posedge Clock); #1;
        total_cnt++;
        if (obs_a !== e_vec) $display("FAIL reset_idle_a got=%h want=%h", obs_a, e_vec);
        else pass_cnt++;
    endtask

    task automatic test_directed_run();
        sc_skip = 1'b0; sc_T = 150; we_zero = 1'b1;
        go_t = 2; ud_t = 7; s2_t = 108; s1_t = 130;
        apply_reset();
        for (int t = 0; t < 145; t++) begin
            @(posedge Clock); #1; drive_at(t);
            @(negedge Clock); model_at(t, e_vec);
            total_cnt++;
            if (obs !== e_vec) $display("FAIL directed t=%0d got=%h want=%h", t, obs, e_vec);
            else pass_cnt++;
        end
        total_cnt++;
        if (a_phase !== 32'd20 || a_done !== 1'b1)
            $display("FAIL directed_end phase=%0d done=%b want phase=20 done=1", a_phase, a_done);
        else pass_cnt++;
    endtask

    task automatic test_skip();
        sc_skip = 1'b1; sc_T = 50; we_zero = 1'b0;
        go_t = 1; ud_t = 4; s2_t = 6; s1_t = 30;
        apply_reset();
        for (int t = 0; t < 45; t++) begin
            @(posedge Clock); #1; drive_at(t);
            @(negedge Clock); model_at(t, e_vec);
            total_cnt++;
            if (obs !== e_vec) $display("FAIL skip t=%0d got=%h want=%h", t, obs, e_vec);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout();
        sc_skip = 1'b1; sc_T = 50; we_zero = 1'b1;
        go_t = 0; ud_t = 3; s2_t = BIG; s1_t = BIG;
        apply_reset();
        for (int t = 0; t < 75; t++) begin
            @(posedge Clock); #1; drive_at(t);
            @(negedge Clock); model_at(t, e_vec);
            total_cnt++;
            if (obs !== e_vec) $display("FAIL timeout t=%0d got=%h want=%h", t, obs, e_vec);
            else pass_cnt++;
        end
    endtask

    // Stop on exactly the last allowed RUN cycle, and stop during the kick cycle.
    task automatic test_stop_edges();
        for (int k = 0; k < 2; k++) begin
            sc_skip = 1'b1; sc_T = 50; we_zero = 1'b0;
            go_t = 0; ud_t = 2; s2_t = BIG;
            s1_t = (k == 0) ? 53 : 3;
            apply_reset();
            for (int t = 0; t < 62; t++) begin
                @(posedge Clock); #1; drive_at(t);
                @(negedge Clock); model_at(t, e_vec);
                total_cnt++;
                if (obs !== e_vec) $display("FAIL stop_edge%0d t=%0d got=%h want=%h", k, t, obs, e_vec);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_random_runs();
        int n;
        for (int i = 0; i < 6; i++) begin
            sc_skip = 1'b0; sc_T = 150; we_zero = 1'b0;
            go_t = $urandom_range(0, 3);
            ud_t = go_t + 1 + $urandom_range(0, 6);
            s2_t = (i == 0) ? BIG : ud_t + 1 + $urandom_range(0, 160);
            s1_t = (i == 0) ? BIG : s2_t + 2 + $urandom_range(0, 40);
            n = imax((i == 0) ? 0 : s1_t, ud_t + 152) + 5;
            apply_reset();
            for (int t = 0; t < n; t++) begin
                @(posedge Clock); #1; drive_at(t);
                @(negedge Clock); model_at(t, e_vec);
                total_cnt++;
                if (obs !== e_vec) $display("FAIL random%0d t=%0d got=%h want=%h", i, t, obs, e_vec);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_midrun();
        sc_skip = 1'b0; sc_T = 150; we_zero = 1'b0;
        go_t = 1; ud_t = 4; s2_t = 90; s1_t = 100;
        apply_reset();
        for (int t = 0; t < 40; t++) begin
            @(posedge Clock); #1; drive_at(t);
            @(negedge Clock); model_at(t, e_vec);
            total_cnt++;
            if (obs !== e_vec) $display("FAIL midrun_pre t=%0d got=%h want=%h", t, obs, e_vec);
            else pass_cnt++;
        end
        @(posedge Clock); #2;
        rst_a_n = 1'b0;
        clear_inputs();
        #1;
        e_vec = {2'd0, 5'b00000, u_we, u_addr, u_data, 32'd0};
        total_cnt++;
        if (obs_a !== e_vec) $display("FAIL midrun_reset got=%h want=%h", obs_a, e_vec);
        else pass_cnt++;
        go_t = 2; ud_t = 6; s2_t = 30; s1_t = 50;
        @(negedge Clock); rst_a_n = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(posedge Clock); #1; drive_at(t);
            @(negedge Clock); model_at(t, e_vec);
            total_cnt++;
            if (obs !== e_vec) $display("FAIL midrun_post t=%0d got=%h want=%h", t, obs, e_vec);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_directed_run();
        test_skip();
        test_timeout();
        test_stop_edges();
        test_random_runs();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
